decode_hazard_stage: RTL
========================

# decode_hazard_stage

Parametrised decode stage for the RV32I merge-sort pipeline: decodes the IF/ID instruction into an active-high control bundle, registers it with operands fields into the ID/EX register, and owns load-use stalling, branch/jump flush and downstream backpressure. It sits between IF/ID and EX and supersedes the purely combinational control decoder.

## Interface
- XLEN, 32, width of PC and sign-extended immediate (32 or 64)
- LOAD_USE_STALL, 1, bubbles inserted on load-use hazard (1..3)
- FLUSH_SLOTS, 1, incoming instructions discarded per redirect, current one included (1..3)

- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- if_valid  in  1  IF/ID holds an instruction
- if_inst  in  32  instruction word
- if_pc  in  XLEN  its PC
- id_ready  out  1  stage consumes if_inst this cycle (combinational)
- ex_ready  in  1  EX accepts ID/EX contents
- ex_redirect  in  1  EX resolved taken branch/jump
- ex_valid  out  1  ID/EX holds a real instruction
- ex_pc, ex_imm  out  XLEN  registered PC, sign-extended immediate
- ex_rs1, ex_rs2, ex_rd  out  5  register indices
- ex_alu_op  out  4  {alt, funct3}
- ex_reg_write, ex_mem_write, ex_mem_read, ex_alu_imm, ex_branch, ex_jal, ex_jalr, ex_lui, ex_auipc, ex_shamt  out  1 each  control bundle
- illegal  out  1  one-cycle pulse, unknown opcode consumed

## Operation
- Opcodes (full 7 bits): R 0110011, OP-IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111; anything else illegal.
- reg_write: R, OP-IMM, LOAD, JAL, JALR, LUI, AUIPC. mem_write: STORE. mem_read: LOAD. alu_imm: OP-IMM, LOAD, STORE, JALR, AUIPC. shamt: OP-IMM with funct3 001/101.
- alu_op: R → {inst[30], funct3}; OP-IMM → {funct3==101 ? inst[30] : 0, funct3}; BRANCH → {0, funct3}; all others 0000.
- Immediates I/S/B/U/J per ISA, sign-extended to XLEN; R-type 0.
- rs1 used by R, OP-IMM, LOAD, STORE, BRANCH, JALR; rs2 used by R, STORE, BRANCH.
- Hazard: ex_valid & ex_mem_read & ex_rd≠0 & ex_rd equals a used rs of decoded if_inst.
- FSM RUN / STALL / FLUSH, counter cnt width clog2(max param+1).
- RUN: if_valid & ex_ready & no hazard → id_ready=1, load ID/EX, ex_valid=1. Hazard & ex_ready → id_ready=0, ex_valid←0; LOAD_USE_STALL=1 stays RUN, else STALL with cnt=LOAD_USE_STALL-1.
- STALL: id_ready=0, bubble each ex_ready cycle, cnt−1; at cnt=1 bubble then RUN.
- FLUSH: id_ready=1, valid inputs discarded, ex_valid←0, cnt−1 per discarded instruction; at 0 → RUN.
- ex_redirect (any state, ignores ex_ready): id_ready=1, current if_inst discarded, ex_valid←0, cnt cleared; FLUSH with cnt=FLUSH_SLOTS-1 if >1, else RUN. Redirect in FLUSH restarts count.
- ex_ready=0 and no redirect: all ex_* hold, id_ready=0, cnt frozen.
- Illegal consumed in RUN: id_ready=1, ex_valid←0, illegal=1 next cycle.
- Priority: reset > redirect > hazard/STALL > backpressure.

## Timing
- Reset: ex_valid, all control bits, ex_pc, ex_imm, register indices, ex_alu_op, illegal = 0; state RUN, cnt 0; id_ready=0 in reset cycle.
- Latency 1 cycle from id_ready&if_valid to ex_* update.
- id_ready depends combinationally on state, hazard, ex_ready, ex_redirect; no combinational path if_inst → ex_*.
- Bubbles on ex_valid=0 also force all control bits 0.
- Reset mid-STALL/FLUSH returns to RUN next cycle, no residual bubble.

## Test plan
- addi x1,x0,5 (0x00500093) → next cycle ex_valid=1, ex_rd=1, ex_imm=5, reg_write=1, alu_imm=1, alu_op=0000.
- lw x2,0(x1) (0x0000A103) then add x3,x2,x1 (0x001101B3), LOAD_USE_STALL=1 → one bubble, id_ready low 1 cycle, add in EX 2 cycles after lw; LOAD_USE_STALL=2 → two bubbles; lw x0 then use x0 → none.
- ex_redirect with FLUSH_SLOTS=2, back-to-back valid input → two instructions dropped, ex_valid 0 two cycles, third issues.
- ex_ready=0 three cycles with valid input → ex_* frozen, id_ready=0; release → pipeline resumes with no loss/duplication.
- redirect coincident with load-use hazard → flush wins, no STALL entered; illegal 0x0000007F → ex_valid 0, illegal pulses 1 cycle.
- reset asserted in STALL (LOAD_USE_STALL=3) → next cycle all outputs 0, state RUN.

Source files
------------

// File: rtl/decode_hazard_stage.sv
// decode_hazard_stage
//   RV32I decode stage: decodes the IF/ID instruction into an active-high
//   control bundle, registers it with operand fields into ID/EX, and owns
//   load-use stalling, branch/jump flush and downstream backpressure.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   RUN   | normal issue; single-bubble load-use handled in place
//   STALL | extra load-use bubbles, cnt = bubbles still to insert
//   FLUSH | wrong-path instructions discarded, cnt = still to discard
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   if_valid/if_inst/if_pc     IF/ID instruction
//   id_ready                   instruction consumed this cycle (comb)
//   ex_ready, ex_redirect      EX accept / taken branch or jump
//   ex_valid, ex_pc, ex_imm    ID/EX valid, PC, sign-extended immediate
//   ex_rs1/ex_rs2/ex_rd        raw register index fields
//   ex_alu_op                  {alt, funct3}
//   ex_reg_write .. ex_shamt   control bundle (zero in bubbles)
//   illegal                    one-cycle pulse after an unknown opcode is consumed
module decode_hazard_stage #(
  parameter int XLEN           = 32,
  parameter int LOAD_USE_STALL = 1,
  parameter int FLUSH_SLOTS    = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [31:0]     if_inst,
  input  logic [XLEN-1:0] if_pc,
  output logic            id_ready,
  input  logic            ex_ready,
  input  logic            ex_redirect,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [3:0]      ex_alu_op,
  output logic            ex_reg_write,
  output logic            ex_mem_write,
  output logic            ex_mem_read,
  output logic            ex_alu_imm,
  output logic            ex_branch,
  output logic            ex_jal,
  output logic            ex_jalr,
  output logic            ex_lui,
  output logic            ex_auipc,
  output logic            ex_shamt,
  output logic            illegal
);

  localparam int MAXP = (LOAD_USE_STALL > FLUSH_SLOTS) ? LOAD_USE_STALL : FLUSH_SLOTS;
  localparam int CW   = $clog2(MAXP + 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {S_RUN, S_STALL, S_FLUSH} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          load, bubble, illegal_nxt;

  function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  // ---------------- decode ----------------
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rs1, rs2, rd;
  logic is_r, is_opi, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;
  logic legal, use_rs1, use_rs2, hazard;
  logic [XLEN-1:0] d_imm;
  logic [3:0]      d_alu_op;

  assign opcode    = if_inst[6:0];
  assign funct3    = if_inst[14:12];
  assign rd        = if_inst[11:7];
  assign rs1       = if_inst[19:15];
  assign rs2       = if_inst[24:20];
  assign is_r      = (opcode == OP_R);
  assign is_opi    = (opcode == OP_IMM);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_lui    = (opcode == OP_LUI);
  assign is_auipc  = (opcode == OP_AUIPC);
  assign legal     = is_r | is_opi | is_load | is_store | is_branch | is_jal |
                     is_jalr | is_lui | is_auipc;
  assign use_rs1   = is_r | is_opi | is_load | is_store | is_branch | is_jalr;
  assign use_rs2   = is_r | is_store | is_branch;

  // Only a real instruction waiting in IF/ID can create a hazard.
  assign hazard = if_valid & ex_valid & ex_mem_read & (ex_rd != 5'd0) &
                  ((use_rs1 & (ex_rd == rs1)) | (use_rs2 & (ex_rd == rs2)));

  always_comb begin
    d_imm = '0;
    if (is_opi || is_load || is_jalr)
      d_imm = sext({{20{if_inst[31]}}, if_inst[31:20]});
    else if (is_store)
      d_imm = sext({{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]});
    else if (is_branch)
      d_imm = sext({{19{if_inst[31]}}, if_inst[31], if_inst[7], if_inst[30:25],
                    if_inst[11:8], 1'b0});
    else if (is_lui || is_auipc)
      d_imm = sext({if_inst[31:12], 12'b0});
    else if (is_jal)
      d_imm = sext({{11{if_inst[31]}}, if_inst[31], if_inst[19:12], if_inst[20],
                    if_inst[30:21], 1'b0});
  end

  always_comb begin
    d_alu_op = 4'b0000;
    if (is_r)
      d_alu_op = {if_inst[30], funct3};
    else if (is_opi)
      d_alu_op = {(funct3 == 3'b101) ? if_inst[30] : 1'b0, funct3};
    else if (is_branch)
      d_alu_op = {1'b0, funct3};
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    id_ready    = 1'b0;
    load        = 1'b0;
    bubble      = 1'b0;
    illegal_nxt = 1'b0;
    if (!reset) begin
      if (ex_redirect) begin
        // Current IF/ID instruction is wrong-path: it counts as the first flushed slot.
        id_ready = 1'b1;
        bubble   = 1'b1;
        if (FLUSH_SLOTS > 1) begin
          state_nxt = S_FLUSH;
          cnt_nxt   = CW'(FLUSH_SLOTS - 1);
        end else begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
        end
      end else if (ex_ready) begin
        case (state)
          S_RUN: begin
            if (hazard) begin
              bubble = 1'b1;
              if (LOAD_USE_STALL > 1) begin
                state_nxt = S_STALL;
                cnt_nxt   = CW'(LOAD_USE_STALL - 1);
              end
            end else begin
              id_ready = 1'b1;
              if (if_valid && legal) begin
                load = 1'b1;
              end else begin
                bubble      = 1'b1;
                illegal_nxt = if_valid;
              end
            end
          end
          S_STALL: begin
            bubble = 1'b1;
            if (cnt <= CW'(1)) begin
              state_nxt = S_RUN;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt - CW'(1);
            end
          end
          S_FLUSH: begin
            id_ready = 1'b1;
            bubble   = 1'b1;
            if (if_valid) begin
              if (cnt <= CW'(1)) begin
                state_nxt = S_RUN;
                cnt_nxt   = '0;
              end else begin
                cnt_nxt = cnt - CW'(1);
              end
            end
          end
          default: begin
            state_nxt = S_RUN;
            cnt_nxt   = '0;
          end
        endcase
      end
    end
  end

  // ---------------- ID/EX register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_imm       <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_alu_op    <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_alu_imm   <= 1'b0;
      ex_branch    <= 1'b0;
      ex_jal       <= 1'b0;
      ex_jalr      <= 1'b0;
      ex_lui       <= 1'b0;
      ex_auipc     <= 1'b0;
      ex_shamt     <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      illegal <= illegal_nxt;
      if (load) begin
        ex_valid     <= 1'b1;
        ex_pc        <= if_pc;
        ex_imm       <= d_imm;
        ex_rs1       <= rs1;
        ex_rs2       <= rs2;
        ex_rd        <= rd;
        ex_alu_op    <= d_alu_op;
        ex_reg_write <= is_r | is_opi | is_load | is_jal | is_jalr | is_lui | is_auipc;
        ex_mem_write <= is_store;
        ex_mem_read  <= is_load;
        ex_alu_imm   <= is_opi | is_load | is_store | is_jalr | is_auipc;
        ex_branch    <= is_branch;
        ex_jal       <= is_jal;
        ex_jalr      <= is_jalr;
        ex_lui       <= is_lui;
        ex_auipc     <= is_auipc;
        ex_shamt     <= is_opi & (funct3[1:0] == 2'b01);
      end else if (bubble) begin
        // PC/imm/indices are don't-care in a bubble and simply hold.
        ex_valid     <= 1'b0;
        ex_alu_op    <= '0;
        ex_reg_write <= 1'b0;
        ex_mem_write <= 1'b0;
        ex_mem_read  <= 1'b0;
        ex_alu_imm   <= 1'b0;
        ex_branch    <= 1'b0;
        ex_jal       <= 1'b0;
        ex_jalr      <= 1'b0;
        ex_lui       <= 1'b0;
        ex_auipc     <= 1'b0;
        ex_shamt     <= 1'b0;
      end
    end
  end

endmodule
